round_sequencer: RTL and testbench



---
 rtl/round_sequencer_pkg.sv | 25 ++
 rtl/round_sequencer_if.sv | 23 ++
 rtl/round_sequencer_sat_counter.sv | 24 ++
 rtl/round_sequencer.sv | 121 ++++++++++++
 tb/tb_round_sequencer.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/round_sequencer_pkg.sv
// round_pkg: shared state encoding, widths and default constants for the round sequencer
package round_pkg;
    localparam int INTERVAL_W         = 3;
    localparam int LEVEL_W            = 4;
    localparam int DEF_START_INTERVAL = 7;
    localparam int DEF_MIN_INTERVAL   = 1;
    localparam int DEF_MAX_MISSES     = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESTART = 3'd1,
        S_RUN     = 3'd2,
        S_HIT     = 3'd3,
        S_MISS    = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    // One step faster, but never below the floor
    function automatic logic [INTERVAL_W-1:0] shrink_interval(
        input logic [INTERVAL_W-1:0] cur,
        input logic [INTERVAL_W-1:0] floor_v
    );
        return (cur > floor_v) ? cur - 1'b1 : floor_v;
    endfunction
endpackage

// File: rtl/round_sequencer_if.sv
// round_sequencer_if: game inputs and timer/display outputs of the round sequencer
interface round_sequencer_if #(parameter int SCORE_W = 8);
    logic                            start;
    logic                            hit;
    logic                            timeout;
    logic [round_pkg::INTERVAL_W-1:0] interval;
    logic                            dir;
    logic                            tmr_rst_n;
    logic                            mole_active;
    logic [SCORE_W-1:0]              score;
    logic [1:0]                      misses;
    logic                            game_over;

    modport master (
        input  start, hit, timeout,
        output interval, dir, tmr_rst_n, mole_active, score, misses, game_over
    );

    modport slave (
        output start, hit, timeout,
        input  interval, dir, tmr_rst_n, mole_active, score, misses, game_over
    );
endinterface

// File: rtl/round_sequencer_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear (clear wins over enable)
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    // Count up on enable and stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (i_clr)
            r_q <= '0;
        else if (i_en && r_q != '1)
            r_q <= r_q + 1'b1;
    end

    assign o_q = r_q;
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: drives mole rounds on the interval timer, scores hits, counts misses, speeds up per level
module round_sequencer
    import round_pkg::*;
#(
    parameter int   SCORE_W        = 8,
    parameter int   MAX_MISSES     = DEF_MAX_MISSES,
    parameter int   HITS_PER_LEVEL = 4,
    parameter int   START_INTERVAL = DEF_START_INTERVAL,
    parameter int   MIN_INTERVAL   = DEF_MIN_INTERVAL,
    parameter logic COUNT_DIR      = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    round_sequencer_if.master bus
);
    localparam logic [INTERVAL_W-1:0] L_START = INTERVAL_W'(START_INTERVAL);
    localparam logic [INTERVAL_W-1:0] L_MIN   = INTERVAL_W'(MIN_INTERVAL);
    localparam logic [LEVEL_W-1:0]    L_LAST  = LEVEL_W'(HITS_PER_LEVEL - 1);
    localparam logic [1:0]            L_MAXM  = 2'(MAX_MISSES);

    state_t                r_state;
    logic [INTERVAL_W-1:0] r_interval;
    logic                  r_tmr_rst_n;
    logic                  r_mole_active;
    logic [1:0]            r_misses;
    logic                  r_game_over;
    logic [SCORE_W-1:0]    w_score;
    logic [LEVEL_W-1:0]    w_level_hits;
    logic                  w_begin;
    logic                  w_hit;
    logic                  w_level_up;

    // Counter updates coincide with the transition into HIT so score is visible one cycle after the hit
    assign w_begin    = (r_state == S_IDLE || r_state == S_OVER) && bus.start;
    assign w_hit      = (r_state == S_RUN) && bus.hit;
    assign w_level_up = w_hit && (w_level_hits == L_LAST);

    sat_counter #(.W(SCORE_W)) u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_begin),
        .i_en  (w_hit),
        .o_q   (w_score)
    );

    sat_counter #(.W(LEVEL_W)) u_level (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_begin || w_level_up),
        .i_en  (w_hit),
        .o_q   (w_level_hits)
    );

    // Round FSM; outputs are set on entry to each state so they are registered yet aligned with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_interval    <= L_START;
            r_tmr_rst_n   <= 1'b0;
            r_mole_active <= 1'b0;
            r_misses      <= 2'd0;
            r_game_over   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (bus.start) begin
                        r_state       <= S_RESTART;
                        r_interval    <= L_START;
                        r_misses      <= 2'd0;
                        r_game_over   <= 1'b0;
                        r_tmr_rst_n   <= 1'b0;
                        r_mole_active <= 1'b0;
                    end
                end
                S_RESTART: begin
                    r_state       <= S_RUN;
                    r_tmr_rst_n   <= 1'b1;
                    r_mole_active <= 1'b1;
                end
                S_RUN: begin
                    if (bus.hit) begin
                        r_state       <= S_HIT;
                        r_mole_active <= 1'b0;
                        if (w_level_up)
                            r_interval <= shrink_interval(r_interval, L_MIN);
                    end else if (bus.timeout) begin
                        r_state       <= S_MISS;
                        r_mole_active <= 1'b0;
                        r_misses      <= r_misses + 2'd1;
                    end
                end
                S_HIT: begin
                    r_state     <= S_RESTART;
                    r_tmr_rst_n <= 1'b0;
                end
                S_MISS: begin
                    r_tmr_rst_n <= 1'b0;
                    if (r_misses == L_MAXM) begin
                        r_state     <= S_OVER;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state <= S_RESTART;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_tmr_rst_n   <= 1'b0;
                    r_mole_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.interval    = r_interval;
    assign bus.dir         = COUNT_DIR;
    assign bus.tmr_rst_n   = r_tmr_rst_n;
    assign bus.mole_active = r_mole_active;
    assign bus.score       = w_score;
    assign bus.misses      = r_misses;
    assign bus.game_over   = r_game_over;
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: randomized directed rounds against a hit/miss tally model
module tb_round_sequencer;
    localparam int HPL    = 4;
    localparam int START  = 7;
    localparam int MINI   = 1;
    localparam int MAXM   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic hit = 1'b0;
    logic timeout = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   m_hits = 0;
    int   m_misses = 0;

    always #5 clk = ~clk;

    round_sequencer_if #(.SCORE_W(8)) b8 ();
    round_sequencer_if #(.SCORE_W(3)) b3 ();

    assign b8.start = start;
    assign b8.hit = hit;
    assign b8.timeout = timeout;
    assign b3.start = start;
    assign b3.hit = hit;
    assign b3.timeout = timeout;

    round_sequencer #(.SCORE_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(b8));
    round_sequencer #(.SCORE_W(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    function automatic int exp_score(input int w);
        int lim = (1 << w) - 1;
        return (m_hits > lim) ? lim : m_hits;
    endfunction

    function automatic int exp_interval();
        int v = START - m_hits / HPL;
        return (v < MINI) ? MINI : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int mole, input int tmr, input int go);
        chk({tag, ".mole"}, 32'(b8.mole_active), 32'(mole));
        if (tmr >= 0) chk({tag, ".tmr_rst_n"}, 32'(b8.tmr_rst_n), 32'(tmr));
        chk({tag, ".game_over"}, 32'(b8.game_over), 32'(go));
        chk({tag, ".score"}, 32'(b8.score), 32'(exp_score(8)));
        chk({tag, ".score3"}, 32'(b3.score), 32'(exp_score(3)));
        chk({tag, ".misses"}, 32'(b8.misses), 32'(m_misses));
        chk({tag, ".interval"}, 32'(b8.interval), 32'(exp_interval()));
        chk({tag, ".dir"}, 32'(b8.dir), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_game(input string tag);
        chk({tag, ".pre_tmr"}, 32'(b8.tmr_rst_n), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_hits = 0;
        m_misses = 0;
        chk_all({tag, ".restart"}, 0, 0, 0);
        timeout = 1'b1;
        hit = 1'($urandom_range(0, 1));
        tick();
        timeout = 1'b0;
        hit = 1'b0;
        chk_all({tag, ".run"}, 1, 1, 0);
    endtask

    task automatic round(input string tag, input int kind, input int idle);
        for (int i = 0; i < idle; i++) begin
            tick();
            chk_all({tag, ".wait"}, 1, 1, 0);
        end
        hit = (kind != 1);
        timeout = (kind != 0);
        tick();
        hit = 1'b0;
        timeout = 1'b0;
        if (kind != 1) m_hits++;
        else m_misses++;
        chk_all({tag, ".resolve"}, 0, -1, 0);
        if (m_misses == MAXM) begin
            tick();
            chk_all({tag, ".over"}, 0, 0, 1);
        end else begin
            tick();
            chk_all({tag, ".restart"}, 0, 0, 0);
            hit = 1'($urandom_range(0, 1));
            timeout = 1'($urandom_range(0, 1));
            tick();
            hit = 1'b0;
            timeout = 1'b0;
            chk_all({tag, ".rerun"}, 1, 1, 0);
        end
    endtask

    initial begin
        #12;
        chk_all("reset", 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_all("idle", 0, 0, 0);
        new_game("start");
        for (int i = 0; i < 28; i++) begin
            round("hit", 0, $urandom_range(0, 2));
            if (i == 3) chk("interval_after4", 32'(b8.interval), 32'd6);
        end
        chk("interval_floor", 32'(b8.interval), 32'(MINI));
        chk("score3_sat", 32'(b3.score), 32'd7);
        round("both", 2, 1);
        chk("both_misses", 32'(b8.misses), 32'd0);
        for (int i = 0; i < 12 && m_misses < MAXM; i++)
            round("rand", ($urandom_range(0, 5) == 0) ? 1 : int'($urandom_range(0, 3) == 0) * 2, $urandom_range(0, 2));
        while (m_misses < MAXM)
            round("miss", 1, $urandom_range(0, 1));
        for (int i = 0; i < 3; i++) begin
            hit = 1'b1;
            tick();
            hit = 1'b0;
            chk_all("over_hit", 0, 0, 1);
        end
        new_game("again");
        for (int i = 0; i < 5; i++) round("g2", 0, 0);
        chk("g2_score", 32'(b8.score), 32'd5);
        #2 rst_n = 1'b0;
        m_hits = 0;
        m_misses = 0;
        #1;
        chk_all("async_rst", 0, 0, 0);
        #3 rst_n = 1'b1;
        tick();
        chk_all("post_rst", 0, 0, 0);
        new_game("fresh");
        round("fresh_hit", 0, 1);
        chk("fresh_score", 32'(b8.score), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
